// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared core constants: RV32I load/store funct3 encodings, LSU FSM states, decode helpers
// Ports: none (package).
package lsu_pkg;

   // RV32I load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // RV32I store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_RESP = 2'b10
   } lsu_state_t;

   // funct3[1:0] encodes access size (00 byte, 01 half, 10 word) for both loads and stores.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      logic bad;
      if (we) begin
         bad = f3[2] || (f3[1:0] == 2'b11);
      end else begin
         bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      return bad;
   endfunction

   function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      logic mis;
      case (f3[1:0])
         2'b01:   mis = addr_lo[0];
         2'b10:   mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - LSU request/response and memory bus signal bundle
// Ports: none; modport master = LSU side (accepts requests, drives memory bus),
//        modport slave = environment side (execute stage + memory).
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
   );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane logic: write strobes, store replication, load extraction/extension
// Ports: funct3 (access type), addr_lo (address bits [1:0]), wdata (store data), rdata (memory word),
//        wstrb (byte strobes), wdata_rep (replicated store data), rdata_ext (extended load data).
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [1:0]  off;
   logic [31:0] lane;

   always_comb begin
      off       = addr_lo;
      wstrb     = 4'b0000;
      wdata_rep = wdata;
      // Misaligned halves/words are pulled down to natural alignment; when they
      // are trapped instead, they never reach the bus so the forcing is harmless.
      case (funct3[1:0])
         2'b00: begin
            wstrb     = 4'b0001 << off;
            wdata_rep = {4{wdata[7:0]}};
         end
         2'b01: begin
            off       = {addr_lo[1], 1'b0};
            wstrb     = 4'b0011 << off;
            wdata_rep = {2{wdata[15:0]}};
         end
         2'b10: begin
            off   = 2'b00;
            wstrb = 4'b1111;
         end
         default: ;
      endcase

      lane = rdata >> {off, 3'b000};

      case (funct3)
         F3_LB:   rdata_ext = {{24{lane[7]}}, lane[7:0]};
         F3_LH:   rdata_ext = {{16{lane[15]}}, lane[15:0]};
         F3_LW:   rdata_ext = lane;
         F3_LBU:  rdata_ext = {24'h0, lane[7:0]};
         F3_LHU:  rdata_ext = {16'h0, lane[15:0]};
         default: rdata_ext = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit: request latch, IDLE/BUS/RESP FSM, bus timeout
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word instead of forcing alignment).
// Parameters: TIMEOUT - BUS cycles to wait for mem_ready before aborting with an error.
// Ports: clk, rst (synchronous, active-high);
//        io (lsu_if.master) - req_* request handshake, resp_* completion pulse, mem_* memory bus.
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic  clk,
   input  logic  rst,
   lsu_if.master io
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   lsu_state_t  state;
   logic [CW-1:0] cnt;
   logic        mem_valid_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   logic        lat_we;
   logic [2:0]  lat_f3;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic        req_bad;
   logic [3:0]  wstrb;
   logic [31:0] wdata_rep;
   logic [31:0] rdata_ext;

   // Legality is judged on the incoming request so the accept cycle can pick BUS or RESP.
`ifdef LSU_MISALIGN_TRAP_EN
   assign req_bad = f3_illegal(io.req_we, io.req_funct3) ||
                    addr_misaligned(io.req_funct3, io.req_addr[1:0]);
`else
   assign req_bad = f3_illegal(io.req_we, io.req_funct3);
`endif

   lsu_align u_align (
      .funct3    (lat_f3),
      .addr_lo   (lat_addr[1:0]),
      .wdata     (lat_wdata),
      .rdata     (io.mem_rdata),
      .wstrb     (wstrb),
      .wdata_rep (wdata_rep),
      .rdata_ext (rdata_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         mem_valid_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
         lat_we       <= 1'b0;
         lat_f3       <= 3'b000;
         lat_addr     <= 32'h0;
         lat_wdata    <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (io.req_valid) begin
                  lat_we    <= io.req_we;
                  lat_f3    <= io.req_funct3;
                  lat_addr  <= io.req_addr;
                  lat_wdata <= io.req_wdata;
                  cnt       <= '0;
                  if (req_bad) begin
                     state        <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'h0;
                  end else begin
                     state       <= ST_BUS;
                     mem_valid_q <= 1'b1;
                  end
               end
            end
            ST_BUS: begin
               if (io.mem_ready) begin
                  state        <= ST_RESP;
                  mem_valid_q  <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= lat_we ? 32'h0 : rdata_ext;
               end else if (cnt == CNT_LAST) begin
                  state        <= ST_RESP;
                  mem_valid_q  <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= 32'h0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: begin
               state        <= ST_IDLE;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'h0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign io.req_ready  = (state == ST_IDLE);
   assign io.resp_valid = resp_valid_q;
   assign io.resp_err   = resp_err_q;
   assign io.resp_rdata = resp_rdata_q;

   // Bus fields come straight from the latched request, so they hold for the whole BUS phase.
   assign io.mem_valid = mem_valid_q;
   assign io.mem_we    = lat_we;
   assign io.mem_addr  = {lat_addr[31:2], 2'b00};
   assign io.mem_wstrb = wstrb;
   assign io.mem_wdata = wdata_rep;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu: directed cases, randomized traffic, timeout and reset abort
// Ports: none (top-level bench); instantiates lsu (TIMEOUT=255) and lsu (TIMEOUT=4).
module tb_lsu;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   lsu_if io ();
   lsu_if io_t ();

   lsu dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   lsu #(.TIMEOUT(4)) dut_t (
      .clk (clk),
      .rst (rst),
      .io  (io_t)
   );

   always #5 clk = ~clk;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s %s: observed=0x%08h expected=0x%08h", tag, what, obs, exp);
      end
   endtask

   // Reference model: access size in bytes, lanes chosen by arithmetic on the address.
   function automatic bit m_illegal(input bit we, input logic [2:0] f3);
      if (we) return !(f3 inside {3'b000, 3'b001, 3'b010});
      return !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   endfunction

   function automatic int m_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int m_off(input logic [2:0] f3, input logic [31:0] addr);
      int sz = m_size(f3);
      int a  = int'(addr[1:0]);
      return (a / sz) * sz;
   endfunction

   function automatic bit m_bad(input bit we, input logic [2:0] f3, input logic [31:0] addr);
      int a = int'(addr[1:0]);
      return m_illegal(we, f3) || (TRAP && ((a % m_size(f3)) != 0));
   endfunction

   function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] addr);
      logic [3:0] s = 4'b0000;
      int sz = m_size(f3);
      int off = m_off(f3, addr);
      for (int i = 0; i < 4; i++) begin
         if (i >= off && i < off + sz) s[i] = 1'b1;
      end
      return s;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wdata);
      logic [31:0] r = 32'h0;
      int sz = m_size(f3);
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = wdata[8*(i % sz) +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
      int sz = m_size(f3);
      int off = m_off(f3, addr);
      logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*sz)) - 32'h1);
      logic [31:0] v = (rdata >> (8*off)) & mask;
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   // Issues one request on io, serves it with wait_n wait states, checks every cycle.
   task automatic run_txn(input string tag, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int wait_n,
                          output logic [31:0] o_rdata, output logic [31:0] o_addr,
                          output logic [3:0] o_strb, output logic [31:0] o_wdata,
                          output int o_cycles);
      bit bad = m_bad(we, f3, addr);
      bit done = 1'b0;
      int n = 0;
      o_addr   = 32'h0;
      o_strb   = 4'h0;
      o_wdata  = 32'h0;
      o_cycles = 0;
      chk(tag, "req_ready idle", 32'(io.req_ready), 32'h1);
      io.req_valid  = 1'b1;
      io.req_we     = we;
      io.req_funct3 = f3;
      io.req_addr   = addr;
      io.req_wdata  = wdata;
      @(posedge clk); #1;
      io.req_valid  = 1'b0;
      io.req_we     = ~we;
      io.req_funct3 = 3'($urandom);
      io.req_addr   = $urandom;
      io.req_wdata  = $urandom;
      chk(tag, "req_ready busy", 32'(io.req_ready), 32'h0);
      if (!bad) begin
         while (!done && n < 64) begin
            chk(tag, "mem_valid bus", 32'(io.mem_valid), 32'h1);
            chk(tag, "resp_valid bus", 32'(io.resp_valid), 32'h0);
            chk(tag, "mem_addr", io.mem_addr, addr & ~32'h3);
            chk(tag, "mem_we", 32'(io.mem_we), 32'(we));
            chk(tag, "mem_wstrb", 32'(io.mem_wstrb), 32'(m_strb(f3, addr)));
            if (we) chk(tag, "mem_wdata", io.mem_wdata, m_wdata(f3, wdata));
            o_addr  = io.mem_addr;
            o_strb  = io.mem_wstrb;
            o_wdata = io.mem_wdata;
            io.mem_ready = (n == wait_n);
            io.mem_rdata = (n == wait_n) ? rdata : $urandom;
            @(posedge clk); #1;
            io.mem_ready = 1'b0;
            done = (n == wait_n);
            n++;
         end
         o_cycles = n;
      end
      chk(tag, "mem_valid resp", 32'(io.mem_valid), 32'h0);
      chk(tag, "resp_valid", 32'(io.resp_valid), 32'h1);
      chk(tag, "resp_err", 32'(io.resp_err), 32'(bad));
      chk(tag, "resp_rdata", io.resp_rdata, (bad || we) ? 32'h0 : m_load(f3, addr, rdata));
      o_rdata = io.resp_rdata;
      @(posedge clk); #1;
      chk(tag, "resp_valid after", 32'(io.resp_valid), 32'h0);
      chk(tag, "req_ready after", 32'(io.req_ready), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r_rd;
      logic [31:0] r_addr;
      logic [31:0] r_wd;
      logic [3:0]  r_st;
      int          r_cyc;
      int          lat;
      bit          rw;
      logic [2:0]  rf3;

      io.req_valid = 1'b0;  io.req_we = 1'b0;  io.req_funct3 = 3'b000;
      io.req_addr = 32'h0;  io.req_wdata = 32'h0;
      io.mem_ready = 1'b0;  io.mem_rdata = 32'h0;
      io_t.req_valid = 1'b0;  io_t.req_we = 1'b0;  io_t.req_funct3 = 3'b000;
      io_t.req_addr = 32'h0;  io_t.req_wdata = 32'h0;
      io_t.mem_ready = 1'b0;  io_t.mem_rdata = 32'h0;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", "req_ready", 32'(io.req_ready), 32'h1);
      chk("reset", "mem_valid", 32'(io.mem_valid), 32'h0);
      chk("reset", "resp_valid", 32'(io.resp_valid), 32'h0);
      chk("reset", "resp_rdata", io.resp_rdata, 32'h0);
      chk("reset", "resp_err", 32'(io.resp_err), 32'h0);
      chk("reset", "mem_addr", io.mem_addr, 32'h0);
      chk("reset", "mem_we", 32'(io.mem_we), 32'h0);
      chk("reset", "t mem_valid", 32'(io_t.mem_valid), 32'h0);
      rst = 1'b0;

      // LB sign-extended from lane 3, zero-wait
      run_txn("lb_1003", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, r_rd, r_addr, r_st, r_wd, r_cyc);
      chk("lb_1003", "rdata const", r_rd, 32'hFFFF_FF80);
      chk("lb_1003", "addr const", r_addr, 32'h0000_1000);
      chk("lb_1003", "strb const", 32'(r_st), 32'h8);
      chk("lb_1003", "bus cycles", 32'(r_cyc), 32'd1);

      // SH to upper half
      run_txn("sh_2002", 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, r_rd, r_addr, r_st, r_wd, r_cyc);
      chk("sh_2002", "strb const", 32'(r_st), 32'hC);
      chk("sh_2002", "wdata const", r_wd, 32'hABCD_ABCD);
      chk("sh_2002", "rdata const", r_rd, 32'h0);

      // LW misaligned: trapped or forced to word alignment
      run_txn("lw_3001", 1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'hCAFE_BABE, 0, r_rd, r_addr, r_st, r_wd, r_cyc);
      chk("lw_3001", "bus cycles", 32'(r_cyc), TRAP ? 32'd0 : 32'd1);
      chk("lw_3001", "rdata const", r_rd, TRAP ? 32'h0 : 32'hCAFE_BABE);

      // LHU with 5 wait states: bus fields checked on each of the 6 cycles
      run_txn("lhu_4002", 1'b0, 3'b101, 32'h0000_4002, 32'h0, 32'hBEEF_0000, 5, r_rd, r_addr, r_st, r_wd, r_cyc);
      chk("lhu_4002", "bus cycles", 32'(r_cyc), 32'd6);
      chk("lhu_4002", "rdata const", r_rd, 32'h0000_BEEF);

      // Illegal encodings never touch the bus
      run_txn("ld_f3_011", 1'b0, 3'b011, 32'h0000_0010, 32'h0, 32'h1111_1111, 0, r_rd, r_addr, r_st, r_wd, r_cyc);
      chk("ld_f3_011", "bus cycles", 32'(r_cyc), 32'd0);
      run_txn("st_f3_100", 1'b1, 3'b100, 32'h0000_0020, 32'h5555_5555, 32'h0, 0, r_rd, r_addr, r_st, r_wd, r_cyc);
      run_txn("st_f3_011", 1'b1, 3'b011, 32'h0000_0024, 32'h5555_5555, 32'h0, 0, r_rd, r_addr, r_st, r_wd, r_cyc);

      // Misaligned LH: trapped, or low half selected
      run_txn("lh_5001", 1'b0, 3'b001, 32'h0000_5001, 32'h0, 32'h1234_8765, 1, r_rd, r_addr, r_st, r_wd, r_cyc);

      // mem_ready while idle has no effect
      io.mem_ready = 1'b1;
      @(posedge clk); #1;
      io.mem_ready = 1'b0;
      chk("idle_ready", "mem_valid", 32'(io.mem_valid), 32'h0);
      chk("idle_ready", "resp_valid", 32'(io.resp_valid), 32'h0);
      chk("idle_ready", "req_ready", 32'(io.req_ready), 32'h1);

      // Randomized traffic, including illegal and misaligned requests
      for (int i = 0; i < 60; i++) begin
         rw  = 1'($urandom);
         rf3 = 3'($urandom);
         run_txn("rand", rw, rf3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                 r_rd, r_addr, r_st, r_wd, r_cyc);
      end

      // Timeout on the TIMEOUT=4 instance
      io_t.req_valid  = 1'b1;
      io_t.req_we     = 1'b0;
      io_t.req_funct3 = 3'b010;
      io_t.req_addr   = 32'h0000_7000;
      @(posedge clk); #1;
      io_t.req_valid = 1'b0;
      lat = 0;
      while (io_t.mem_valid && lat < 20) begin
         chk("timeout", "resp_valid wait", 32'(io_t.resp_valid), 32'h0);
         lat++;
         @(posedge clk); #1;
      end
      chk("timeout", "bus cycles", 32'(lat), 32'd4);
      chk("timeout", "resp_valid", 32'(io_t.resp_valid), 32'h1);
      chk("timeout", "resp_err", 32'(io_t.resp_err), 32'h1);
      chk("timeout", "resp_rdata", io_t.resp_rdata, 32'h0);
      chk("timeout", "req_ready resp", 32'(io_t.req_ready), 32'h0);
      @(posedge clk); #1;
      chk("timeout", "req_ready next", 32'(io_t.req_ready), 32'h1);
      chk("timeout", "resp_valid next", 32'(io_t.resp_valid), 32'h0);

      // Reset in BUS cycle 2 abandons the transaction
      io.req_valid  = 1'b1;
      io.req_we     = 1'b0;
      io.req_funct3 = 3'b010;
      io.req_addr   = 32'h0000_6000;
      @(posedge clk); #1;
      io.req_valid = 1'b0;
      chk("rst_bus", "mem_valid c1", 32'(io.mem_valid), 32'h1);
      @(posedge clk); #1;
      chk("rst_bus", "mem_valid c2", 32'(io.mem_valid), 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_bus", "mem_valid", 32'(io.mem_valid), 32'h0);
      chk("rst_bus", "resp_valid", 32'(io.resp_valid), 32'h0);
      chk("rst_bus", "req_ready", 32'(io.req_ready), 32'h1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rst_bus", "resp_valid later", 32'(io.resp_valid), 32'h0);
         chk("rst_bus", "mem_valid later", 32'(io.mem_valid), 32'h0);
      end

      // Normal operation after the abort
      run_txn("sb_post_rst", 1'b1, 3'b000, 32'h0000_8001, 32'h0000_00A5, 32'h0, 2, r_rd, r_addr, r_st, r_wd, r_cyc);
      chk("sb_post_rst", "wdata const", r_wd, 32'hA5A5_A5A5);
      chk("sb_post_rst", "strb const", 32'(r_st), 32'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
